// File: rtl/dataram_arb.sv
// dataram_arb
// Two-port arbiter and sequencer in front of the 8-bit scratch data RAM.
// Port A (core load/store unit) and port B (host/debug loader) share the
// RAM's single READ/WRITE/MEM_ADDR/MEM_DIN/MEM_DOUT interface. One access
// is in flight at a time, the RAM's one-cycle registered read latency is
// absorbed by a CAPTURE state, and the RAM's post-reset initialisation
// cycle is covered by an INIT state.
//
// Optional feature, macro DATARAM_ARB_RR_EN:
//   defined   -> round-robin tie-break using a 1-bit last-winner register
//   undefined -> fixed A-over-B priority
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata     port A request (held until a_gnt)
//   a_gnt, a_rvalid               port A grant and read-valid pulses
//   b_req/b_we/b_addr/b_wdata     port B request (held until b_gnt)
//   b_gnt, b_rvalid               port B grant and read-valid pulses
//   rdata                         shared read data, qualified by *_rvalid
//   err                           pulses with a grant below WIN_BASE
//   mem_read, mem_write           RAM command strobes (never both 1)
//   mem_addr, mem_din             RAM address and write data
//   mem_dout                      RAM read data (valid one cycle after READ)

module dataram_arb #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int WIN_BASE = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, CAPTURE} state_t;

  state_t            state_q;
  logic              owner_q;    // 0 = port A owns the access, 1 = port B
  logic              rd_q;       // access in flight is a read
  logic              a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q, err_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q, rdata_q;

  logic              pick_b_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;
  logic              sel_err_d;

`ifdef DATARAM_ARB_RR_EN
  logic              last_q;     // 1 = B won the previous grant

  // Round-robin tie-break: on a tie the port that did not win last goes.
  // last_q resets to B so that A takes the first tie.
  always_comb begin
    pick_b_d = b_req && (!a_req || !last_q);
  end
`else
  // Fixed priority: B only wins when A is not asking.
  always_comb begin
    pick_b_d = b_req && !a_req;
  end
`endif

  // Mux the winning requester's command fields and flag out-of-window use.
  always_comb begin
    sel_we_d    = pick_b_d ? b_we    : a_we;
    sel_addr_d  = pick_b_d ? b_addr  : a_addr;
    sel_wdata_d = pick_b_d ? b_wdata : a_wdata;
    sel_err_d   = sel_addr_d < ADDR_W'(WIN_BASE);
  end

  // Sequencer FSM. Every output is a register written here; the pulse
  // outputs default to 0 each cycle so they last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      owner_q     <= 1'b0;
      rd_q        <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      rdata_q     <= '0;
`ifdef DATARAM_ARB_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        // The RAM loads its default contents during this cycle.
        INIT: state_q <= IDLE;
        IDLE: begin
          if (a_req || b_req) begin
            owner_q     <= pick_b_d;
            rd_q        <= !sel_we_d;
            mem_read_q  <= !sel_we_d;
            mem_write_q <= sel_we_d;
            mem_addr_q  <= sel_addr_d;
            mem_din_q   <= sel_wdata_d;
            a_gnt_q     <= !pick_b_d;
            b_gnt_q     <= pick_b_d;
            err_q       <= sel_err_d;
`ifdef DATARAM_ARB_RR_EN
            last_q      <= pick_b_d;
`endif
            state_q     <= ISSUE;
          end
        end
        // The RAM samples the command at the end of this cycle, so the
        // strobe is dropped here to keep it exactly one cycle wide.
        ISSUE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= rd_q ? CAPTURE : IDLE;
        end
        CAPTURE: begin
          rdata_q    <= mem_dout;
          a_rvalid_q <= !owner_q;
          b_rvalid_q <= owner_q;
          state_q    <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign err       = err_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign rdata     = rdata_q;

endmodule
